// File: rtl/seg_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg_scan_controller                                           |
// | Purpose  : Scans NUM_DIGITS common-anode digits through one shared hex   |
// |            decoder; display updates are applied only at frame edges.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_value,
  input  logic [NUM_DIGITS-1:0]   upd_en,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic                    lz_blank,
  output logic [3:0]              digit,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  phase_t                  phase_q, phase_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d, pval_q, pval_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d, pen_q, pen_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, pdp_q, pdp_d;
  logic                    pend_q, pend_d;
  logic                    upd_ready_q, upd_ready_d;
  logic [3:0]              digit_q, digit_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_start_q, frame_start_d;

  logic                    boundary;
  logic                    accept;
  logic                    visible;
  logic                    drive;
  logic [NUM_DIGITS-1:0]   sel;

  // zero_from[i]: nibbles i..NUM_DIGITS-1 of the shown value are all zero
  logic [NUM_DIGITS:1]     zero_from;
  logic [NUM_DIGITS-1:0]   lz_sup;

  assign zero_from[NUM_DIGITS] = 1'b1;
  assign lz_sup[0]             = 1'b0;

  for (genvar i = NUM_DIGITS - 1; i >= 1; i--) begin : g_lz
    assign zero_from[i] = zero_from[i+1] && (val_q[4*i +: 4] == 4'h0);
    assign lz_sup[i]    = zero_from[i];
  end

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    boundary = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d    = '0;
        boundary = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    phase_d = (cnt_d < CNT_BLANK) ? PH_BLANK : PH_DRIVE;

    // Pending data is promoted before a same-edge accept can refill it;
    // both cannot coincide on pend=1 because ready is low then.
    accept = upd_valid && upd_ready_q;
    val_d  = val_q;
    en_d   = en_q;
    dp_d   = dp_q;
    pval_d = pval_q;
    pen_d  = pen_q;
    pdp_d  = pdp_q;
    pend_d = pend_q;
    if (boundary && pend_q) begin
      val_d  = pval_q;
      en_d   = pen_q;
      dp_d   = pdp_q;
      pend_d = 1'b0;
    end
    if (accept) begin
      pval_d = upd_value;
      pen_d  = upd_en;
      pdp_d  = upd_dp;
      pend_d = 1'b1;
    end
    upd_ready_d   = ~pend_d;
    frame_start_d = boundary;

    sel          = '0;
    sel[idx_q]   = 1'b1;
    visible      = en_q[idx_q] && !(lz_blank && lz_sup[idx_q]);
    drive        = (phase_q == PH_DRIVE) && visible;
    digit_d      = val_q[{idx_q, 2'b00} +: 4];
    an_n_d       = drive ? ~sel : '1;
    dp_n_d       = drive ? ~dp_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= PH_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      val_q         <= '0;
      en_q          <= '1;
      dp_q          <= '0;
      pval_q        <= '0;
      pen_q         <= '0;
      pdp_q         <= '0;
      pend_q        <= 1'b0;
      upd_ready_q   <= 1'b0;
      digit_q       <= 4'h0;
      an_n_q        <= '1;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      val_q         <= val_d;
      en_q          <= en_d;
      dp_q          <= dp_d;
      pval_q        <= pval_d;
      pen_q         <= pen_d;
      pdp_q         <= pdp_d;
      pend_q        <= pend_d;
      upd_ready_q   <= upd_ready_d;
      digit_q       <= digit_d;
      an_n_q        <= an_n_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign upd_ready   = upd_ready_q;
  assign digit       = digit_q;
  assign an_n        = an_n_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire
